// File: rtl/dispatch_steer.sv
// rtl/dispatch_steer.sv - in-order dispatch queue steering head uops to per-pipe RS entries, with DMT
// Optional DISPATCH_STATS_EN adds saturating perf_disp_cnt / perf_blk_cnt outputs.
module dispatch_steer #(
  parameter int DISP_WIDTH = 2,
  parameter int NUM_FUS    = 4,
  parameter int Q_DEPTH    = 16,
  parameter int NUM_PREGS  = 64,
  parameter int RS_ENTRIES = 16,
  parameter int PAYLOAD_W  = 64,
  localparam int FU_W   = $clog2(NUM_FUS),
  localparam int PREG_W = $clog2(NUM_PREGS),
  localparam int COL_W  = $clog2(RS_ENTRIES),
  localparam int LOC_W  = FU_W + COL_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           flush,
  input  logic [DISP_WIDTH-1:0]          in_valid,
  output logic                           in_ready,
  input  logic [DISP_WIDTH*NUM_FUS-1:0]  in_pipe_mask,
  input  logic [DISP_WIDTH*PREG_W-1:0]   in_dst_preg,
  input  logic [DISP_WIDTH*PREG_W-1:0]   in_src1_preg,
  input  logic [DISP_WIDTH*PREG_W-1:0]   in_src2_preg,
  input  logic [DISP_WIDTH-1:0]          in_src1_en,
  input  logic [DISP_WIDTH-1:0]          in_src2_en,
  input  logic [DISP_WIDTH*PAYLOAD_W-1:0] in_payload,
  input  logic                           rob_full,
  output logic [DISP_WIDTH-1:0]          rob_alloc,
  input  logic [NUM_FUS-1:0]             rs_free,
  input  logic [NUM_FUS*COL_W-1:0]       rs_free_idx,
  output logic [NUM_FUS-1:0]             rs_disp_valid,
  output logic [NUM_FUS-1:0]             rs_src1_dep_en,
  output logic [NUM_FUS-1:0]             rs_src2_dep_en,
  output logic [NUM_FUS*LOC_W-1:0]       rs_src1_dep_loc,
  output logic [NUM_FUS*LOC_W-1:0]       rs_src2_dep_loc,
  output logic [NUM_FUS*PAYLOAD_W-1:0]   rs_payload,
  input  logic [NUM_FUS-1:0]             iss_valid,
  input  logic [NUM_FUS*PREG_W-1:0]      iss_dst_preg
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                    perf_disp_cnt,
  output logic [31:0]                    perf_blk_cnt
`endif
);
  localparam int Q_W   = $clog2(Q_DEPTH);
  localparam int CNT_W = Q_W + 1;

  typedef struct packed {
    logic [NUM_FUS-1:0]   mask;
    logic [PREG_W-1:0]    dst;
    logic [PREG_W-1:0]    src1;
    logic [PREG_W-1:0]    src2;
    logic                 src1_en;
    logic                 src2_en;
    logic [PAYLOAD_W-1:0] payload;
  } uop_t;

  uop_t mem_q [Q_DEPTH];
  uop_t mem_d [Q_DEPTH];
  logic [Q_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d, enq_n, deq_n;
  logic [FU_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_PREGS-1:0] dmt_vld_q, dmt_vld_d;
  logic [LOC_W-1:0]     dmt_loc_q [NUM_PREGS];
  logic [LOC_W-1:0]     dmt_loc_d [NUM_PREGS];

  uop_t                  hd [DISP_WIDTH];
  logic [FU_W-1:0]       slot_pipe [DISP_WIDTH];
  logic [LOC_W-1:0]      slot_loc [DISP_WIDTH];
  logic [DISP_WIDTH-1:0] grant, disp;
  logic [NUM_FUS-1:0]    claimed;
  logic                  go, chain, found, rr_adv;
  int                    p;
  logic [1:0][DISP_WIDTH-1:0] dep_en_w;
  logic [LOC_W-1:0]      dep_loc_w [2][DISP_WIDTH];
  logic [PREG_W-1:0]     sp;
  logic                  se;

  assign rob_alloc = in_valid & {DISP_WIDTH{in_ready}};

  always_comb begin
    in_ready = (count_q <= CNT_W'(Q_DEPTH - DISP_WIDTH)) && !rob_full && !flush;
    mem_d = mem_q;
    enq_n = '0;
    if (in_valid[0] && in_ready) begin
      for (int k = 0; k < DISP_WIDTH; k++) begin
        if (in_valid[k]) begin
          mem_d[tail_q + Q_W'(k)].mask    = in_pipe_mask[k*NUM_FUS +: NUM_FUS];
          mem_d[tail_q + Q_W'(k)].dst     = in_dst_preg[k*PREG_W +: PREG_W];
          mem_d[tail_q + Q_W'(k)].src1    = in_src1_preg[k*PREG_W +: PREG_W];
          mem_d[tail_q + Q_W'(k)].src2    = in_src2_preg[k*PREG_W +: PREG_W];
          mem_d[tail_q + Q_W'(k)].src1_en = in_src1_en[k];
          mem_d[tail_q + Q_W'(k)].src2_en = in_src2_en[k];
          mem_d[tail_q + Q_W'(k)].payload = in_payload[k*PAYLOAD_W +: PAYLOAD_W];
          enq_n = enq_n + CNT_W'(1);
        end
      end
    end
  end

  // Round-robin pipe pick per head slot; the first slot that cannot go ends the granted prefix.
  always_comb begin
    go      = !(stall || flush || rst);
    claimed = '0;
    chain   = 1'b1;
    rr_adv  = 1'b0;
    grant   = '0;
    found   = 1'b0;
    p       = 0;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      hd[k]        = mem_q[head_q + Q_W'(k)];
      slot_pipe[k] = '0;
      found        = 1'b0;
      for (int i = 0; i < NUM_FUS; i++) begin
        p = (int'(rr_ptr_q) + i) % NUM_FUS;
        if (!found && hd[k].mask[p] && rs_free[p] && !claimed[p]) begin
          found        = 1'b1;
          slot_pipe[k] = FU_W'(p);
        end
      end
      slot_loc[k] = {slot_pipe[k], rs_free_idx[int'(slot_pipe[k])*COL_W +: COL_W]};
      if (chain && (CNT_W'(k) < count_q) && found) begin
        grant[k]               = 1'b1;
        claimed[slot_pipe[k]]  = 1'b1;
      end else begin
        if (chain && (CNT_W'(k) < count_q) && (k > 0) && |(hd[k].mask & rs_free & claimed))
          rr_adv = 1'b1;
        chain = 1'b0;
      end
    end
    disp = go ? grant : '0;
  end

  // Source readiness: DMT lookup, cancelled by a same-cycle issue, overridden by older group members.
  always_comb begin
    dep_en_w = '0;
    sp       = '0;
    se       = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < DISP_WIDTH; k++) begin
        sp = (s == 0) ? hd[k].src1 : hd[k].src2;
        se = (s == 0) ? hd[k].src1_en : hd[k].src2_en;
        dep_en_w[s][k] = se && dmt_vld_q[sp];
        dep_loc_w[s][k] = dmt_loc_q[sp];
        for (int f = 0; f < NUM_FUS; f++)
          if (iss_valid[f] && iss_dst_preg[f*PREG_W +: PREG_W] == sp) dep_en_w[s][k] = 1'b0;
        for (int j = 0; j < k; j++) begin
          if (se && disp[j] && hd[j].dst == sp) begin
            dep_en_w[s][k]  = 1'b1;
            dep_loc_w[s][k] = slot_loc[j];
          end
        end
      end
    end
  end

  always_comb begin
    rs_disp_valid   = '0;
    rs_src1_dep_en  = '0;
    rs_src2_dep_en  = '0;
    rs_src1_dep_loc = '0;
    rs_src2_dep_loc = '0;
    rs_payload      = '0;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      if (disp[k]) begin
        rs_disp_valid[slot_pipe[k]]  = 1'b1;
        rs_src1_dep_en[slot_pipe[k]] = dep_en_w[0][k];
        rs_src2_dep_en[slot_pipe[k]] = dep_en_w[1][k];
        rs_src1_dep_loc[int'(slot_pipe[k])*LOC_W +: LOC_W]     = dep_loc_w[0][k];
        rs_src2_dep_loc[int'(slot_pipe[k])*LOC_W +: LOC_W]     = dep_loc_w[1][k];
        rs_payload[int'(slot_pipe[k])*PAYLOAD_W +: PAYLOAD_W] = hd[k].payload;
      end
    end
  end

  always_comb begin
    deq_n = '0;
    for (int k = 0; k < DISP_WIDTH; k++) deq_n = deq_n + CNT_W'(disp[k]);
    head_d   = head_q + Q_W'(deq_n);
    tail_d   = tail_q + Q_W'(enq_n);
    count_d  = count_q + enq_n - deq_n;
    rr_ptr_d = rr_ptr_q;
    if (go && rr_adv)
      rr_ptr_d = (rr_ptr_q == FU_W'(NUM_FUS - 1)) ? '0 : rr_ptr_q + FU_W'(1);
    dmt_vld_d = dmt_vld_q;
    dmt_loc_d = dmt_loc_q;
    for (int f = 0; f < NUM_FUS; f++)
      if (iss_valid[f]) dmt_vld_d[iss_dst_preg[f*PREG_W +: PREG_W]] = 1'b0;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      if (disp[k]) begin
        dmt_vld_d[hd[k].dst] = 1'b1;
        dmt_loc_d[hd[k].dst] = slot_loc[k];
      end
    end
    if (flush) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      dmt_vld_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rr_ptr_q  <= '0;
      dmt_vld_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rr_ptr_q  <= rr_ptr_d;
      dmt_vld_q <= dmt_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q     <= mem_d;
    dmt_loc_q <= dmt_loc_d;
  end

`ifdef DISPATCH_STATS_EN
  logic [31:0] disp_cnt_q, disp_cnt_d, blk_cnt_q, blk_cnt_d;
  logic [32:0] disp_sum;

  always_comb begin
    disp_sum   = {1'b0, disp_cnt_q} + 33'(deq_n);
    disp_cnt_d = disp_sum[32] ? '1 : disp_sum[31:0];
    blk_cnt_d  = blk_cnt_q;
    if ((count_q != '0) && !stall && (deq_n == '0) && (blk_cnt_q != '1))
      blk_cnt_d = blk_cnt_q + 32'd1;
    if (flush) begin
      disp_cnt_d = '0;
      blk_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_cnt_q <= '0;
      blk_cnt_q  <= '0;
    end else begin
      disp_cnt_q <= disp_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  assign perf_disp_cnt = disp_cnt_q;
  assign perf_blk_cnt  = blk_cnt_q;
`endif

endmodule
